ans_ht_stf_detector: RTL

Receive-side counterpart of `ans_ht_stf_generator`. The block consumes the baseband 32-bit IQ sample stream and detects the HT short training field by its 16-sample periodicity, using lag-16 delayed autocorrelation normalised by windowed power. It sits in the receive datapath ahead of HT-LTF timing and channel estimation. It provides a one-shot detection strobe plus a sticky found flag that the receive controller clears.

---
 rtl/ans_ht_stf_pkg.sv | 17 +
 rtl/ans_ht_stf_detector_moving_sum.sv | 36 +++
 rtl/ans_ht_stf_detector.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ans_ht_stf_pkg.sv
// Constants and FSM encoding shared by the HT-STF generator and detector.
package ans_ht_stf_pkg;

    localparam int STF_PERIOD = 16;
    localparam int STF_LEN    = 80;
    localparam int IQ_W       = 16;
    localparam int PROD_SHIFT = 8;
    localparam int SUM_W      = 29;
    localparam int PROD_W     = 2 * IQ_W + 1 - PROD_SHIFT;

    typedef logic [1:0] stf_state_t;

    localparam stf_state_t FILL     = 2'd0;
    localparam stf_state_t SEARCH   = 2'd1;
    localparam stf_state_t DETECTED = 2'd2;

endpackage

// File: rtl/ans_ht_stf_detector_moving_sum.sv
// ans_moving_sum: 16-deep window of signed products with an exact running sum.
module ans_moving_sum
    import ans_ht_stf_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr,
    input  logic signed [PROD_W-1:0] din,
    output logic signed [SUM_W-1:0]  sum
);

    logic signed [PROD_W-1:0] dly [STF_PERIOD];
    logic signed [SUM_W-1:0]  din_x;
    logic signed [SUM_W-1:0]  old_x;

    always_comb begin
        din_x = {{(SUM_W-PROD_W){din[PROD_W-1]}}, din};
        old_x = {{(SUM_W-PROD_W){dly[STF_PERIOD-1][PROD_W-1]}}, dly[STF_PERIOD-1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < STF_PERIOD; i++) dly[i] <= '0;
            sum <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < STF_PERIOD; i++) dly[i] <= '0;
            sum <= '0;
        end else if (en) begin
            dly[0] <= din;
            for (int unsigned i = 1; i < STF_PERIOD; i++) dly[i] <= dly[i-1];
            sum <= sum + din_x - old_x;
        end
    end

endmodule

// File: rtl/ans_ht_stf_detector.sv
// HT-STF detector: lag-16 autocorrelation over windowed power with plateau FSM.
// Optional debug taps (dbg_metric, dbg_power, dbg_qualify) under ANS_HT_STF_DET_DEBUG_EN.
module ans_ht_stf_detector
    import ans_ht_stf_pkg::*;
#(
    parameter int unsigned      THRESH_Q3   = 6,
    parameter logic [SUM_W-1:0] MIN_POWER   = 29'd4096,
    parameter int unsigned      PLATEAU_LEN = 48
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_iq,
    input  logic        in_valid,
    input  logic        stf_clear,
    output logic        ht_stf_detected,
    output logic        ht_stf_found,
    output logic [5:0]  plateau_cnt
`ifdef ANS_HT_STF_DET_DEBUG_EN
    ,
    output logic [29:0] dbg_metric,
    output logic [28:0] dbg_power,
    output logic        dbg_qualify
`endif
);

    logic [31:0] smp_dly [STF_PERIOD];
    logic        s0_valid;
    logic [31:0] s0_cur;
    logic [31:0] s0_old;

    // Input register ahead of S1 so the multipliers start from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < STF_PERIOD; i++) smp_dly[i] <= '0;
            s0_valid <= 1'b0;
            s0_cur   <= '0;
            s0_old   <= '0;
        end else if (stf_clear) begin
            for (int unsigned i = 0; i < STF_PERIOD; i++) smp_dly[i] <= '0;
            s0_valid <= 1'b0;
            s0_cur   <= '0;
            s0_old   <= '0;
        end else begin
            s0_valid <= in_valid;
            if (in_valid) begin
                s0_cur     <= in_iq;
                s0_old     <= smp_dly[STF_PERIOD-1];
                smp_dly[0] <= in_iq;
                for (int unsigned i = 1; i < STF_PERIOD; i++) smp_dly[i] <= smp_dly[i-1];
            end
        end
    end

    logic signed [32:0] ci, cq, oi, oq;
    logic signed [32:0] re_full, im_full, pw_full;

    always_comb begin
        ci      = {{17{s0_cur[31]}}, s0_cur[31:16]};
        cq      = {{17{s0_cur[15]}}, s0_cur[15:0]};
        oi      = {{17{s0_old[31]}}, s0_old[31:16]};
        oq      = {{17{s0_old[15]}}, s0_old[15:0]};
        re_full = ci * oi + cq * oq;
        im_full = cq * oi - ci * oq;
        pw_full = ci * ci + cq * cq;
    end

    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_re, s1_im, s1_pw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_pw    <= '0;
        end else if (stf_clear) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_pw    <= '0;
        end else begin
            s1_valid <= s0_valid;
            s1_re    <= re_full[32:PROD_SHIFT];
            s1_im    <= im_full[32:PROD_SHIFT];
            s1_pw    <= pw_full[32:PROD_SHIFT];
        end
    end

    logic signed [SUM_W-1:0] cre, cim, pwr;
    logic                    s2_valid;

    ans_moving_sum u_sum_re (.clk(clk), .reset(reset), .en(s1_valid), .clr(stf_clear), .din(s1_re), .sum(cre));
    ans_moving_sum u_sum_im (.clk(clk), .reset(reset), .en(s1_valid), .clr(stf_clear), .din(s1_im), .sum(cim));
    ans_moving_sum u_sum_pw (.clk(clk), .reset(reset), .en(s1_valid), .clr(stf_clear), .din(s1_pw), .sum(pwr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          s2_valid <= 1'b0;
        else if (stf_clear) s2_valid <= 1'b0;
        else                s2_valid <= s1_valid;
    end

    logic [SUM_W-1:0] abs_re, abs_im, pwr_u;
    logic [29:0]      metric;
    logic [32:0]      lhs, rhs;
    logic             qualify;

    always_comb begin
        abs_re  = cre[SUM_W-1] ? -cre : cre;
        abs_im  = cim[SUM_W-1] ? -cim : cim;
        pwr_u   = pwr;
        metric  = {1'b0, abs_re} + {1'b0, abs_im};
        lhs     = {metric, 3'b000};
        rhs     = {4'b0000, pwr_u} * 33'(THRESH_Q3);
        qualify = (lhs >= rhs) && (pwr_u >= MIN_POWER);
    end

    stf_state_t state;
    logic [4:0] fill_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= FILL;
            fill_cnt        <= '0;
            plateau_cnt     <= '0;
            ht_stf_found    <= 1'b0;
            ht_stf_detected <= 1'b0;
        end else if (stf_clear) begin
            state           <= FILL;
            fill_cnt        <= '0;
            plateau_cnt     <= '0;
            ht_stf_found    <= 1'b0;
            ht_stf_detected <= 1'b0;
        end else begin
            ht_stf_detected <= 1'b0;
            if (s2_valid) begin
                case (state)
                    FILL: begin
                        fill_cnt <= fill_cnt + 5'd1;
                        if (fill_cnt == 5'(2 * STF_PERIOD - 1)) state <= SEARCH;
                    end
                    SEARCH: begin
                        if (qualify) begin
                            plateau_cnt <= plateau_cnt + 6'd1;
                            if ({1'b0, plateau_cnt} + 7'd1 == 7'(PLATEAU_LEN)) begin
                                ht_stf_detected <= 1'b1;
                                ht_stf_found    <= 1'b1;
                                state           <= DETECTED;
                            end
                        end else begin
                            plateau_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ANS_HT_STF_DET_DEBUG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_metric  <= '0;
            dbg_power   <= '0;
            dbg_qualify <= 1'b0;
        end else begin
            dbg_metric  <= metric;
            dbg_power   <= pwr_u;
            dbg_qualify <= qualify;
        end
    end
`endif

endmodule
